// File: rtl/game_sequencer.sv
// Rally sequencer for the paddle game: serve hold, per-frame ball motion, miss handling,
// lives and score. Sole owner of the ball centre position.
module game_sequencer #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int BALL_R       = 10,
  parameter int BALL_STEP    = 2,
  parameter int START_X      = 320,
  parameter int START_Y      = 240,
  parameter int SERVE_FRAMES = 60,
  parameter int MISS_FRAMES  = 30,
  parameter int LIVES        = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [3:0] dir_state,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       ball_en,
  output logic       playing,
  output logic [3:0] lives_left,
  output logic [7:0] score,
  output logic       game_over
);

  typedef enum logic [2:0] {S_IDLE, S_SERVE, S_PLAY, S_MISS, S_OVER} state_t;

  localparam int CNT_MAX = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   SERVE_CNT  = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0]   MISS_CNT   = CNT_W'(MISS_FRAMES);
  localparam logic [9:0]         HOME_X     = 10'(START_X);
  localparam logic [9:0]         HOME_Y     = 10'(START_Y);
  localparam logic [3:0]         LIVES_INIT = 4'(LIVES);
  localparam logic signed [10:0] STEP_P     = 11'(BALL_STEP);
  localparam logic signed [10:0] STEP_N     = 11'(-BALL_STEP);
  localparam logic signed [10:0] X_MIN      = 11'(BALL_R);
  localparam logic signed [10:0] X_MAX      = 11'(SCREEN_W - 1 - BALL_R);
  localparam logic signed [10:0] Y_MIN      = 11'(BALL_R);
  localparam logic signed [10:0] Y_MAX      = 11'(SCREEN_H - 1 - BALL_R);

  state_t           state_q, state_d;
  logic [9:0]       ball_x_q, ball_x_d;
  logic [9:0]       ball_y_q, ball_y_d;
  logic             ball_en_q, ball_en_d;
  logic             playing_q, playing_d;
  logic [3:0]       lives_q, lives_d;
  logic [7:0]       score_q, score_d;
  logic             game_over_q, game_over_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q;
  logic [3:0]       prev_dir_q;

  logic             start_rise;
  logic             hit;
  logic [CNT_W-1:0] cnt_inc;
  logic signed [10:0] step_x, step_y;
  logic signed [10:0] nx, ny;

  function automatic logic [9:0] clamp_axis(input logic signed [10:0] v,
                                            input logic signed [10:0] lo,
                                            input logic signed [10:0] hi);
    logic signed [10:0] r;
    r = v;
    if (v < lo) r = lo;
    else if (v > hi) r = hi;
    return r[9:0];
  endfunction

  // Per-axis velocity sign for each collision-controller code; codes 9..15 do not move.
  always_comb begin
    step_x = '0;
    step_y = '0;
    case (dir_state)
      4'd0:       begin step_x = '0;     step_y = STEP_P; end
      4'd1, 4'd8: begin step_x = STEP_N; step_y = STEP_N; end
      4'd2, 4'd3: begin step_x = STEP_P; step_y = STEP_N; end
      4'd4, 4'd5: begin step_x = STEP_P; step_y = STEP_P; end
      4'd6, 4'd7: begin step_x = STEP_N; step_y = STEP_P; end
      default:    begin step_x = '0;     step_y = '0;     end
    endcase
  end

  assign start_rise = start & ~start_q;
  // A paddle hit is a transition from a downward-travelling code into an upward one.
  assign hit = (state_q == S_PLAY) &&
               ((prev_dir_q == 4'd0) || (prev_dir_q == 4'd4) || (prev_dir_q == 4'd7)) &&
               ((dir_state == 4'd1) || (dir_state == 4'd2));

  always_comb begin
    state_d     = state_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    ball_en_d   = ball_en_q;
    playing_d   = playing_q;
    lives_d     = lives_q;
    score_d     = score_q;
    game_over_d = game_over_q;
    cnt_d       = cnt_q;
    cnt_inc     = cnt_q + 1'b1;
    nx          = $signed({1'b0, ball_x_q}) + step_x;
    ny          = $signed({1'b0, ball_y_q}) + step_y;

    case (state_q)
      S_IDLE: begin
        ball_x_d  = HOME_X;
        ball_y_d  = HOME_Y;
        ball_en_d = 1'b0;
        if (start_rise) begin
          state_d   = S_SERVE;
          cnt_d     = '0;
          ball_en_d = 1'b1;
        end
      end
      S_SERVE: begin
        ball_x_d  = HOME_X;
        ball_y_d  = HOME_Y;
        ball_en_d = 1'b1;
        if (frame_tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc == SERVE_CNT) begin
            state_d   = S_PLAY;
            playing_d = 1'b1;
          end
        end
      end
      S_PLAY: begin
        if (hit && (score_q != 8'hFF)) score_d = score_q + 8'd1;
        // A miss takes priority over a coincident frame tick: the ball does not move.
        if (dir_state == 4'd9) begin
          state_d   = S_MISS;
          lives_d   = (lives_q != 4'd0) ? lives_q - 4'd1 : 4'd0;
          cnt_d     = '0;
          ball_en_d = 1'b0;
          playing_d = 1'b0;
        end else if (frame_tick) begin
          ball_x_d = clamp_axis(nx, X_MIN, X_MAX);
          ball_y_d = clamp_axis(ny, Y_MIN, Y_MAX);
        end
      end
      S_MISS: begin
        ball_en_d = 1'b0;
        if (frame_tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc == MISS_CNT) begin
            if (lives_q == 4'd0) begin
              state_d     = S_OVER;
              game_over_d = 1'b1;
            end else begin
              state_d   = S_SERVE;
              cnt_d     = '0;
              ball_x_d  = HOME_X;
              ball_y_d  = HOME_Y;
              ball_en_d = 1'b1;
            end
          end
        end
      end
      S_OVER: begin
        game_over_d = 1'b1;
        ball_en_d   = 1'b0;
        if (start_rise) begin
          state_d     = S_SERVE;
          lives_d     = LIVES_INIT;
          score_d     = '0;
          game_over_d = 1'b0;
          cnt_d       = '0;
          ball_x_d    = HOME_X;
          ball_y_d    = HOME_Y;
          ball_en_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ball_x_q    <= HOME_X;
      ball_y_q    <= HOME_Y;
      ball_en_q   <= 1'b0;
      playing_q   <= 1'b0;
      lives_q     <= LIVES_INIT;
      score_q     <= '0;
      game_over_q <= 1'b0;
      cnt_q       <= '0;
      start_q     <= 1'b0;
      prev_dir_q  <= '0;
    end else begin
      state_q     <= state_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      ball_en_q   <= ball_en_d;
      playing_q   <= playing_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      game_over_q <= game_over_d;
      cnt_q       <= cnt_d;
      start_q     <= start;
      prev_dir_q  <= dir_state;
    end
  end

  assign ball_x     = ball_x_q;
  assign ball_y     = ball_y_q;
  assign ball_en    = ball_en_q;
  assign playing    = playing_q;
  assign lives_left = lives_q;
  assign score      = score_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: directed rally scenarios plus random play, each cycle's
// outputs predicted by a rule-level game model and checked by an independent monitor.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic [3:0] dir_state = 4'd0;
  logic [9:0] ball_x, ball_y;
  logic       ball_en, playing, game_over;
  logic [3:0] lives_left;
  logic [7:0] score;

  int n_cmp = 0;
  int n_bad = 0;

  game_sequencer dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start), .dir_state(dir_state),
    .ball_x(ball_x), .ball_y(ball_y), .ball_en(ball_en), .playing(playing),
    .lives_left(lives_left), .score(score), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x, y, en, pl, lives, score, over;
    bit tick;
  } exp_t;
  exp_t sb_q[$];

  // Rule-level model of the game
  localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_MISS = 3, M_OVER = 4;
  int m_mode, m_x, m_y, m_en, m_pl, m_lives, m_score, m_over, m_frames, m_prev_start, m_prev_dir;
  int dx_tab[16] = '{0, -1, 1, 1, 1, 1, -1, -1, -1, 0, 0, 0, 0, 0, 0, 0};
  int dy_tab[16] = '{1, -1, -1, -1, 1, 1, 1, 1, -1, 0, 0, 0, 0, 0, 0, 0};

  function automatic int lim(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_x = 320; m_y = 240; m_en = 0; m_pl = 0; m_lives = 3;
    m_score = 0; m_over = 0; m_frames = 0; m_prev_start = 0; m_prev_dir = 0;
  endtask

  task automatic serve_from_home();
    m_mode = M_SERVE; m_frames = 0; m_en = 1; m_x = 320; m_y = 240;
  endtask

  task automatic model_step(input bit t, input bit s, input int d);
    bit rise;
    bit hit;
    rise = s && !m_prev_start;
    hit  = (m_mode == M_PLAY) && (m_prev_dir inside {0, 4, 7}) && (d inside {1, 2});
    case (m_mode)
      M_IDLE:  if (rise) serve_from_home();
      M_SERVE: if (t) begin
        m_frames++;
        if (m_frames == 60) begin m_mode = M_PLAY; m_pl = 1; end
      end
      M_PLAY: begin
        if (hit) m_score = (m_score < 255) ? m_score + 1 : 255;
        if (d == 9) begin
          m_mode = M_MISS; m_lives--; m_frames = 0; m_en = 0; m_pl = 0;
        end else if (t) begin
          m_x = lim(m_x + 2 * dx_tab[d], 10, 629);
          m_y = lim(m_y + 2 * dy_tab[d], 10, 469);
        end
      end
      M_MISS: if (t) begin
        m_frames++;
        if (m_frames == 30) begin
          if (m_lives == 0) begin m_mode = M_OVER; m_over = 1; end
          else serve_from_home();
        end
      end
      default: if (rise) begin
        m_lives = 3; m_score = 0; m_over = 0;
        serve_from_home();
      end
    endcase
    m_prev_start = s;
    m_prev_dir   = d;
  endtask

  // One clock of stimulus: inputs applied after the falling edge, prediction queued for the monitor
  task automatic cyc(input bit rst, input bit t, input bit s, input int d);
    exp_t e;
    @(negedge clk);
    #1;
    rst_n = !rst; frame_tick = t; start = s; dir_state = 4'(d);
    if (rst) model_reset();
    else model_step(t, s, d);
    e = '{x: m_x, y: m_y, en: m_en, pl: m_pl, lives: m_lives, score: m_score, over: m_over,
          tick: t && !rst};
    sb_q.push_back(e);
  endtask

  task automatic tick_n(input int n, input int d);
    repeat (n) begin
      cyc(0, 1, 0, d);
      cyc(0, 0, 0, d);
    end
  endtask

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // Monitor: every falling edge the DUT presents the result of the previous rising edge
  always begin
    exp_t e;
    @(negedge clk);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_cmp++;
      if (int'(ball_x) != e.x || int'(ball_y) != e.y || int'(ball_en) != e.en ||
          int'(playing) != e.pl || int'(lives_left) != e.lives || int'(score) != e.score ||
          int'(game_over) != e.over) begin
        n_bad++;
        $display("FAIL cycle outputs: got x=%0d y=%0d en=%0d play=%0d lives=%0d score=%0d over=%0d, required x=%0d y=%0d en=%0d play=%0d lives=%0d score=%0d over=%0d",
                 ball_x, ball_y, ball_en, playing, lives_left, score, game_over,
                 e.x, e.y, e.en, e.pl, e.lives, e.score, e.over);
      end else if (e.tick) begin
        $display("frame: x=%0d y=%0d en=%0d play=%0d lives=%0d score=%0d over=%0d",
                 ball_x, ball_y, ball_en, playing, lives_left, score, game_over);
      end
    end
  end

  task automatic goto_play();
    for (int i = 0; i < 3000 && m_mode != M_PLAY; i++) begin
      if (m_mode == M_IDLE || m_mode == M_OVER) begin
        cyc(0, 0, 1, 5);
        cyc(0, 0, 0, 5);
      end else cyc(0, 1, 0, 5);
    end
    cyc(0, 0, 0, 5);
    chk("reach_play", int'(playing), 1);
  endtask

  initial begin
    model_reset();
    repeat (3) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("rst_x", int'(ball_x), 320);
    chk("rst_y", int'(ball_y), 240);
    chk("rst_en", int'(ball_en), 0);
    chk("rst_lives", int'(lives_left), 3);
    chk("rst_score", int'(score), 0);

    // Serve, including a hit-shaped edge that must not score outside PLAY
    cyc(0, 0, 1, 5);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 5);
    chk("serve_en", int'(ball_en), 1);
    chk("serve_no_score", int'(score), 0);
    tick_n(59, 5);
    chk("serve59_play", int'(playing), 0);
    chk("serve59_x", int'(ball_x), 320);
    tick_n(1, 5);
    chk("serve60_play", int'(playing), 1);

    tick_n(10, 5);
    chk("move_x", int'(ball_x), 340);
    chk("move_y", int'(ball_y), 260);

    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("hit_score", int'(score), 1);

    tick_n(200, 4);
    chk("clamp_hi_x", int'(ball_x), 629);
    chk("clamp_hi_y", int'(ball_y), 469);
    tick_n(320, 8);
    chk("clamp_lo_x", int'(ball_x), 10);
    chk("clamp_lo_y", int'(ball_y), 10);

    repeat (260) begin
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 1);
    end
    cyc(0, 0, 0, 1);
    chk("score_sat", int'(score), 255);

    // Miss coincident with a frame tick
    cyc(0, 1, 0, 9);
    cyc(0, 0, 0, 0);
    chk("miss_x", int'(ball_x), 10);
    chk("miss_lives", int'(lives_left), 2);
    chk("miss_en", int'(ball_en), 0);
    tick_n(29, 0);
    chk("miss29_en", int'(ball_en), 0);
    tick_n(1, 0);
    chk("reserve_en", int'(ball_en), 1);
    chk("reserve_x", int'(ball_x), 320);
    chk("reserve_y", int'(ball_y), 240);

    // Random play
    for (int i = 0; i < 4000; i++) begin
      int d;
      if ($urandom_range(0, 99) < 2) d = 9;
      else begin
        d = int'($urandom_range(0, 14));
        if (d >= 9) d++;
      end
      cyc(0, $urandom_range(0, 1) == 0, $urandom_range(0, 40) == 0, d);
    end

    // Reset in the middle of a rally
    goto_play();
    cyc(1, 0, 0, 5);
    cyc(0, 0, 0, 5);
    chk("midrst_x", int'(ball_x), 320);
    chk("midrst_en", int'(ball_en), 0);
    chk("midrst_lives", int'(lives_left), 3);
    chk("midrst_play", int'(playing), 0);

    // Lose every life
    for (int i = 0; i < 20000 && m_mode != M_OVER; i++) begin
      if (m_mode == M_IDLE) begin
        cyc(0, 0, 1, 5);
        cyc(0, 0, 0, 5);
      end else if (m_mode == M_PLAY) cyc(0, 1, 0, 9);
      else cyc(0, 1, 0, 5);
    end
    cyc(0, 0, 0, 5);
    chk("over_flag", int'(game_over), 1);
    chk("over_lives", int'(lives_left), 0);
    chk("over_en", int'(ball_en), 0);

    // Restart with start held high all the way into PLAY
    cyc(0, 0, 1, 5);
    cyc(0, 0, 1, 5);
    chk("restart_lives", int'(lives_left), 3);
    chk("restart_score", int'(score), 0);
    chk("restart_over", int'(game_over), 0);
    chk("restart_en", int'(ball_en), 1);
    repeat (70) begin
      cyc(0, 1, 1, 6);
      cyc(0, 0, 1, 6);
    end
    cyc(0, 0, 0, 6);
    chk("start_held_play", int'(playing), 1);

    cyc(0, 0, 0, 6);
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    chk("drain", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
